// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and constants for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, ACCESS = 2'b01, FINISH = 2'b10} state_t;
  typedef enum logic {OWNER_I = 1'b0, OWNER_D = 1'b1} owner_t;
  localparam int BLOCK_WORDS = 4;
  localparam int OFFSET_W = 2;
  function automatic logic [15:0] block_base(input logic [15:0] a);
    return a & 16'hFFFC;
  endfunction
endpackage

// File: rtl/mem_access_timer.sv
// mem_access_timer: per-word latency countdown with word counter and last-word flag
module mem_access_timer
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                run,
  input  logic [OFFSET_W-1:0] last_idx,
  output logic [OFFSET_W-1:0] word_cnt,
  output logic                word_done,
  output logic                last_word
);
  localparam logic [3:0] RELOAD = 4'(MEM_LATENCY - 1);
  logic [3:0] lat_cnt;
  assign word_done = lat_cnt == 4'd0;
  assign last_word = word_done && word_cnt == last_idx;
  always_ff @(posedge clk) begin
    if (reset || start) begin
      lat_cnt  <= RELOAD;
      word_cnt <= '0;
    end else if (run) begin
      lat_cnt  <= word_done ? RELOAD : lat_cnt - 4'd1;
      word_cnt <= word_done ? word_cnt + 1'b1 : word_cnt;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between I and D cache engines (ARB_D_PRIORITY_EN selects fixed D priority)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        i_flush,
  output logic        i_grant,
  output logic        i_rvalid,
  output logic [1:0]  i_widx,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_grant,
  output logic        d_rvalid,
  output logic [1:0]  d_widx,
  output logic        d_done,
  output logic [15:0] rdata,
  output logic        m_read,
  output logic        m_write,
  output logic [15:0] m_address,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  output logic [1:0]  o_state
);
  state_t state, state_nx;
  owner_t owner, last_owner;
  logic we, abort, eff_abort, rv, pick_d, grant_go, in_access, finish_word, word_done, last_word;
  logic [OFFSET_W-1:0] word_cnt, widx;
  mem_access_timer #(.MEM_LATENCY(MEM_LATENCY)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .start    (grant_go),
    .run      (in_access),
    .last_idx (we ? '0 : OFFSET_W'(BLOCK_WORDS - 1)),
    .word_cnt (word_cnt),
    .word_done(word_done),
    .last_word(last_word)
  );
  always_comb begin
`ifdef ARB_D_PRIORITY_EN
    pick_d = d_req;
`else
    pick_d = d_req && (!i_req || last_owner == OWNER_I);
`endif
    grant_go = state == IDLE && (i_req || d_req);
    in_access = state == ACCESS;
    eff_abort = abort || (i_flush && owner == OWNER_I);
    finish_word = in_access && word_done && (last_word || eff_abort);
    state_nx = grant_go ? ACCESS : finish_word ? FINISH : state == FINISH ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWNER_I;
      last_owner <= OWNER_D;
      we         <= 1'b0;
      abort      <= 1'b0;
      rv         <= 1'b0;
      widx       <= '0;
      rdata      <= 16'h0000;
      m_address  <= 16'h0000;
      m_wdata    <= 16'h0000;
    end else begin
      state <= state_nx;
      abort <= !grant_go && (abort || (in_access && i_flush && owner == OWNER_I));
      rv    <= in_access && word_done && !we && !eff_abort;
      if (in_access && word_done && !we && !eff_abort) begin
        rdata <= m_rdata;
        widx  <= word_cnt;
      end
      if (grant_go) begin
        owner     <= pick_d ? OWNER_D : OWNER_I;
        we        <= pick_d && d_we;
        m_address <= pick_d ? (d_we ? d_addr : block_base(d_addr)) : block_base(i_addr);
        m_wdata   <= pick_d ? d_wdata : m_wdata;
      end else if (in_access && word_done && !last_word) begin
        m_address[1:0] <= m_address[1:0] + 2'd1;
      end
      if (state == FINISH) last_owner <= owner;
    end
  end
  assign i_grant  = state != IDLE && owner == OWNER_I;
  assign d_grant  = state != IDLE && owner == OWNER_D;
  assign m_read   = in_access && !we;
  assign m_write  = in_access && we;
  assign i_rvalid = rv && owner == OWNER_I;
  assign d_rvalid = rv && owner == OWNER_D;
  assign i_widx   = widx;
  assign d_widx   = widx;
  assign i_done   = state == FINISH && owner == OWNER_I;
  assign d_done   = state == FINISH && owner == OWNER_D;
  assign o_state  = state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed checks of mem_port_arbiter against a transaction-timing model
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  localparam int BW = 4;
  logic clk = 0, reset = 1, i_req = 0, i_flush = 0, d_req = 0, d_we = 0;
  logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic i_grant, i_rvalid, i_done, d_grant, d_rvalid, d_done, m_read, m_write;
  logic [1:0] i_widx, d_widx, o_state;
  logic [15:0] rdata, m_address, m_wdata, m_rdata;
  int checks = 0, failures = 0, cyc = 0;
  int md_k = 0, md_nw = 0, md_ab = -1;
  bit md_busy = 0, md_own = 0, md_we = 0, md_last = 1;
  logic [15:0] md_base = 0, md_wd = 0;
  mem_port_arbiter #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_grant(i_grant), .i_rvalid(i_rvalid), .i_widx(i_widx), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_rvalid(d_rvalid), .d_widx(d_widx), .d_done(d_done),
    .rdata(rdata), .m_read(m_read), .m_write(m_write), .m_address(m_address),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .o_state(o_state)
  );
  always #5 clk = ~clk;
  assign m_rdata = m_address ^ 16'hA5A5;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask
  function automatic int send_k();
    return md_ab >= 0 ? (md_ab + 1) * LAT : md_nw * LAT;
  endfunction
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      md_busy = 0;
      md_last = 1;
    end else if (md_busy) begin
      if (!md_own && i_flush && md_ab < 0 && md_k <= send_k()) md_ab = (md_k - 1) / LAT;
      if (md_k == send_k() + 1) begin
        md_busy = 0;
        md_last = md_own;
      end else md_k++;
    end else if (i_req || d_req) begin
`ifdef ARB_D_PRIORITY_EN
      md_own = d_req;
`else
      md_own = d_req && (!i_req || !md_last);
`endif
      md_we = md_own && d_we;
      md_nw = md_we ? 1 : BW;
      md_base = !md_own ? (i_addr & 16'hFFFC) : md_we ? d_addr : (d_addr & 16'hFFFC);
      md_wd = d_wdata;
      md_busy = 1;
      md_k = 1;
      md_ab = -1;
    end
  end
  always @(negedge clk) begin
    int s, w;
    bit act, rv;
    if (cyc >= 1) begin
      s = send_k();
      w = (md_k - 1) / LAT - 1;
      act = md_busy && md_k <= s;
      rv = md_busy && !md_we && md_k > 1 && (md_k - 1) % LAT == 0 && md_k - 1 <= s && w != md_ab;
      chk("state", 16'(o_state), !md_busy ? 16'd0 : act ? 16'd1 : 16'd2);
      chk("grant", 16'({i_grant, d_grant}), 16'({md_busy && !md_own, md_busy && md_own}));
      chk("strobe", 16'({m_read, m_write}), 16'({act && !md_we, act && md_we}));
      chk("done", 16'({i_done, d_done}), 16'({md_busy && !md_own && md_k == s + 1, md_busy && md_own && md_k == s + 1}));
      chk("rvalid", 16'({i_rvalid, d_rvalid}), 16'({rv && !md_own, rv && md_own}));
      if (rv) begin
        chk("widx", 16'(md_own ? d_widx : i_widx), 16'(w));
        chk("rdata", rdata, (md_base + 16'(w)) ^ 16'hA5A5);
      end
      if (act) chk("m_address", m_address, md_we ? md_base : md_base + 16'((md_k - 1) / LAT));
      if (act && md_we) chk("m_wdata", m_wdata, md_wd);
    end
  end
  task automatic tick();
    @(negedge clk);
    if (i_done) i_req = 0;
    if (d_done) d_req = 0;
    i_flush = 0;
    reset = 0;
  endtask
  initial begin
    logic [15:0] rd_tab [4];
    bit got, cur, was_g;
    int prev, ngr;
    rd_tab = '{16'hA5B5, 16'hA5B4, 16'hA5B7, 16'hA5B6};
    repeat (2) @(negedge clk);
    chk("rst_state", 16'(o_state), 16'd0);
    chk("rst_outs", 16'({i_grant, d_grant, m_read, m_write, i_done, d_done, i_rvalid, d_rvalid}), 16'd0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_maddr", m_address, 16'h0000);
    chk("rst_mwdata", m_wdata, 16'h0000);
    tick(); tick();
    i_req = 1; i_addr = 16'h0013;
    for (int n = 1; n <= 10; n++) begin
      tick();
      chk("t1_rvalid", 16'(i_rvalid), 16'(n == 3 || n == 5 || n == 7 || n == 9));
      if (i_rvalid) begin
        chk("t1_widx", 16'(i_widx), 16'((n - 3) / 2));
        chk("t1_rdata", rdata, rd_tab[(n - 3) / 2]);
      end
      chk("t1_done", 16'(i_done), 16'(n == 9));
      if (n <= 8) chk("t1_maddr", m_address, 16'h0010 + 16'((n - 1) / 2));
    end
    tick();
    d_req = 1; d_we = 1; d_addr = 16'h0042; d_wdata = 16'hBEEF;
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk("t2_mwrite", 16'(m_write), 16'(n <= 2));
      if (n <= 2) begin
        chk("t2_maddr", m_address, 16'h0042);
        chk("t2_mwdata", m_wdata, 16'hBEEF);
      end
      chk("t2_done", 16'(d_done), 16'(n == 3));
      chk("t2_rvalid", 16'(d_rvalid), 16'd0);
    end
    reset = 1;
    tick();
    i_req = 1; d_req = 1; d_we = 0; i_addr = 16'h0100; d_addr = 16'h0200;
    tick();
`ifdef ARB_D_PRIORITY_EN
    chk("t3_first", 16'({i_grant, d_grant}), 16'b01);
`else
    chk("t3_first", 16'({i_grant, d_grant}), 16'b10);
`endif
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      got = i_done || d_done;
    end
    chk("t3_done_seen", 16'(got), 16'd1);
    tick();
    chk("t3_gap", 16'({i_grant, d_grant}), 16'b00);
    tick();
`ifdef ARB_D_PRIORITY_EN
    chk("t3_second", 16'({i_grant, d_grant}), 16'b10);
`else
    chk("t3_second", 16'({i_grant, d_grant}), 16'b01);
`endif
    repeat (12) tick();
    i_req = 1; i_addr = 16'h0204;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 3) begin
        chk("t4_rv0", 16'(i_rvalid), 16'd1);
        i_flush = 1;
      end
      if (n == 4) begin
        chk("t4_mread", 16'(m_read), 16'd1);
        d_req = 1; d_we = 0; d_addr = 16'h0300;
      end
      if (n == 5) chk("t4_abort", 16'({i_rvalid, i_done, m_read}), 16'b010);
      if (n == 6) chk("t4_idle", 16'({i_grant, d_grant}), 16'b00);
      if (n == 7) chk("t4_dgrant", 16'({i_grant, d_grant}), 16'b01);
    end
    repeat (12) tick();
    d_req = 1; d_we = 0; d_addr = 16'h1230;
    for (int n = 1; n <= 9; n++) begin
      tick();
      if (n == 5) begin
        chk("t5_rv1", 16'({d_rvalid, d_widx}), 16'b101);
        reset = 1;
      end
      if (n == 6) begin
        chk("t5_rst_outs", 16'({o_state, d_grant, m_read, d_done, d_rvalid}), 16'd0);
        chk("t5_rst_rdata", rdata, 16'h0000);
        chk("t5_rst_maddr", m_address, 16'h0000);
      end
      if (n == 7) chk("t5_restart", m_address, 16'h1230);
      if (n == 9) chk("t5_rv0", 16'({d_rvalid, d_widx}), 16'b100);
    end
    repeat (12) tick();
    i_req = 1; d_req = 1; d_we = 0;
    prev = -1; ngr = 0; was_g = 0;
    for (int n = 0; n < 80; n++) begin
      tick();
      if (!i_req) begin i_req = 1; i_addr = 16'($urandom); end
      if (!d_req) begin d_req = 1; d_we = 0; d_addr = 16'($urandom); end
      if ((i_grant || d_grant) && !was_g) begin
        cur = d_grant;
`ifdef ARB_D_PRIORITY_EN
        chk("t6_dprio", 16'(cur), 16'd1);
`else
        if (prev >= 0) chk("t6_alternate", 16'(cur), 16'(prev == 0));
`endif
        prev = int'(cur);
        ngr++;
      end
      was_g = i_grant || d_grant;
    end
    chk("t6_grants", 16'(ngr >= 3), 16'd1);
    i_req = 0; d_req = 0;
    repeat (12) tick();
    for (int n = 0; n < 2500; n++) begin
      tick();
      if (!i_req && $urandom_range(0, 3) == 0) begin i_req = 1; i_addr = 16'($urandom); end
      if (!d_req && $urandom_range(0, 3) == 0) begin
        d_req = 1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      i_flush = $urandom_range(0, 9) == 0;
      reset = $urandom_range(0, 299) == 0;
    end
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
